// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_pkg
// Purpose  : Shared AHB-Lite encodings for the core-to-AHB master bridge:
//            HTRANS/HBURST/HSIZE values, the bridge state encoding and the
//            alignment predicate used when AHB_MST_ALIGN_CHK_EN is defined.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  // True for a request that must not reach the bus: halfword on an odd
  // address, word not on a 4-byte boundary, or the reserved size 3.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    case ({1'b0, size})
      HSIZE_BYTE: bad = 1'b0;
      HSIZE_HALF: bad = addr_lo[0];
      HSIZE_WORD: bad = (addr_lo != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_mst_lane.sv
`default_nettype none
// ============================================================================
// Module   : ahb_mst_lane
// Purpose  : Combinational byte-lane steering for the AHB master bridge.
//            Write side replicates right-aligned data across all lanes;
//            read side shifts the addressed lane down and zero-extends.
// Ports    : hsize      - transfer size (AHB encoding)
//            addr_lo    - low two address bits of the transfer
//            wdata      - right-aligned core write data
//            hrdata     - raw AHB read bus
//            hwdata_rep - lane-replicated write data for the bus
//            rdata_ext  - right-aligned, zero-extended read data
// Revision : 1.0 - initial release
// ============================================================================
module ahb_mst_lane
  import ahb_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [2:0]        hsize,
  input  logic [1:0]        addr_lo,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [DWIDTH-1:0] hrdata,
  output logic [DWIDTH-1:0] hwdata_rep,
  output logic [DWIDTH-1:0] rdata_ext
);

  logic [DWIDTH-1:0] w_shifted;

  always_comb begin
    w_shifted = hrdata >> {addr_lo, 3'b000};
    case (hsize)
      HSIZE_BYTE: begin
        hwdata_rep = {(DWIDTH/8){wdata[7:0]}};
        rdata_ext  = {{(DWIDTH-8){1'b0}}, w_shifted[7:0]};
      end
      HSIZE_HALF: begin
        hwdata_rep = {(DWIDTH/16){wdata[15:0]}};
        rdata_ext  = {{(DWIDTH-16){1'b0}}, w_shifted[15:0]};
      end
      default: begin
        // Word, and the reserved size 3 when it is let through unchecked.
        hwdata_rep = wdata;
        rdata_ext  = w_shifted;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ahb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ahb_master_bridge
// Purpose  : Single-outstanding core request to AHB-Lite master bridge.
//            IDLE accepts a request, ADDR drives the NONSEQ address phase,
//            DATA waits for hready, RSP returns a one-cycle response.
//            All outputs are registered.
// Config   : AHB_MST_ALIGN_CHK_EN - when defined, misaligned or size=3
//            requests are answered with an error and never reach the bus.
// Ports    : hclk, hreset                       - clock, sync active-high reset
//            req_i/we_i/size_i/addr_i/wdata_i   - core request
//            gnt_o/rvalid_o/rdata_o/err_o       - core handshake and response
//            haddr_o/htrans_o/hwrite_o/hsize_o/hburst_o/hwdata_o - AHB master
//            hready_i/hresp_i/hrdata_i          - AHB slave response
// Revision : 1.0 - initial release
// ============================================================================
module ahb_master_bridge
  import ahb_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [DWIDTH-1:0] rdata_o,
  output logic              err_o,
  output logic [AWIDTH-1:0] haddr_o,
  output logic [1:0]        htrans_o,
  output logic              hwrite_o,
  output logic [2:0]        hsize_o,
  output logic [2:0]        hburst_o,
  output logic [DWIDTH-1:0] hwdata_o,
  input  logic              hready_i,
  input  logic              hresp_i,
  input  logic [DWIDTH-1:0] hrdata_i
);

  state_t            r_state;
  logic              r_gnt;
  logic [1:0]        r_htrans;
  logic              r_rvalid;
  logic              r_err;
  logic [DWIDTH-1:0] r_rdata;
  logic [DWIDTH-1:0] r_hwdata;
  logic              r_we;
  logic [1:0]        r_size;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_wdata;

  logic              w_misaligned;
  logic [DWIDTH-1:0] w_wdata_rep;
  logic [DWIDTH-1:0] w_rdata_ext;

`ifdef AHB_MST_ALIGN_CHK_EN
  assign w_misaligned = is_misaligned(size_i, addr_i[1:0]);
`else
  assign w_misaligned = 1'b0;
`endif

  ahb_mst_lane #(
    .DWIDTH (DWIDTH)
  ) u_lane (
    .hsize      ({1'b0, r_size}),
    .addr_lo    (r_addr[1:0]),
    .wdata      (r_wdata),
    .hrdata     (hrdata_i),
    .hwdata_rep (w_wdata_rep),
    .rdata_ext  (w_rdata_ext)
  );

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state  <= ST_IDLE;
      r_gnt    <= 1'b0;
      r_htrans <= HTRANS_IDLE;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_hwdata <= '0;
      r_we     <= 1'b0;
      r_size   <= 2'b00;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_i && r_gnt) begin
            r_we    <= we_i;
            r_size  <= size_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_gnt   <= 1'b0;
            if (w_misaligned) begin
              // Rejected locally: answer next cycle, bus stays IDLE.
              r_state  <= ST_RSP;
              r_rvalid <= 1'b1;
              r_err    <= 1'b1;
              r_rdata  <= '0;
            end else begin
              r_state  <= ST_ADDR;
              r_htrans <= HTRANS_NONSEQ;
            end
          end else begin
            // Also raises gnt on the first cycle after reset release.
            r_gnt <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (hready_i) begin
            r_state  <= ST_DATA;
            r_htrans <= HTRANS_IDLE;
            r_hwdata <= w_wdata_rep;
          end
        end
        ST_DATA: begin
          // First ERROR cycle (hready low) just waits; the error is taken
          // from hresp on the completing cycle.
          if (hready_i) begin
            r_state  <= ST_RSP;
            r_rvalid <= 1'b1;
            r_err    <= hresp_i;
            r_rdata  <= (r_we || hresp_i) ? '0 : w_rdata_ext;
          end
        end
        ST_RSP: begin
          r_state  <= ST_IDLE;
          r_rvalid <= 1'b0;
          r_err    <= 1'b0;
          r_rdata  <= '0;
          r_gnt    <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt_o    = r_gnt;
  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;
  assign haddr_o  = r_addr;
  assign htrans_o = r_htrans;
  assign hwrite_o = r_we;
  assign hsize_o  = {1'b0, r_size};
  assign hburst_o = HBURST_SINGLE;
  assign hwdata_o = r_hwdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_master_bridge
// Purpose  : Directed self-checking bench for ahb_master_bridge.
//            Covers reset, zero-wait reads/writes of each size, read wait
//            states, address-phase stall, two-cycle ERROR, reset during a
//            transfer and the AHB_MST_ALIGN_CHK_EN rejection path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_master_bridge;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [31:0] haddr_o;
  logic [1:0]  htrans_o;
  logic        hwrite_o;
  logic [2:0]  hsize_o;
  logic [2:0]  hburst_o;
  logic [31:0] hwdata_o;
  logic        hready_i = 1'b1;
  logic        hresp_i = 1'b0;
  logic [31:0] hrdata_i = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 hclk = ~hclk;

  ahb_master_bridge #(
    .AWIDTH (32),
    .DWIDTH (32)
  ) dut (
    .hclk     (hclk),
    .hreset   (hreset),
    .req_i    (req_i),
    .we_i     (we_i),
    .size_i   (size_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .haddr_o  (haddr_o),
    .htrans_o (htrans_o),
    .hwrite_o (hwrite_o),
    .hsize_o  (hsize_o),
    .hburst_o (hburst_o),
    .hwdata_o (hwdata_o),
    .hready_i (hready_i),
    .hresp_i  (hresp_i),
    .hrdata_i (hrdata_i)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // Presents a request in the current (IDLE) cycle; returns in cycle N+1.
  task automatic accept(input string tag, input logic we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata);
    req_i = 1'b1; we_i = we; size_i = size; addr_i = addr; wdata_i = wdata;
    check({tag, "_gnt"}, {31'b0, gnt_o}, 32'd1);
    tick();
    req_i = 1'b0;
  endtask

  // Zero-wait-state transfer with full latency and bus-field checks.
  task automatic xfer(input string tag, input logic we, input logic [1:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] bus_rdata, input logic [31:0] exp_hwdata,
                      input logic [31:0] exp_rdata);
    hready_i = 1'b1; hresp_i = 1'b0; hrdata_i = bus_rdata;
    accept(tag, we, size, addr, wdata);
    check({tag, "_htrans_n1"}, {30'b0, htrans_o}, 32'h2);
    check({tag, "_haddr"}, haddr_o, addr);
    check({tag, "_hsize"}, {29'b0, hsize_o}, {30'b0, size});
    check({tag, "_hwrite"}, {31'b0, hwrite_o}, {31'b0, we});
    check({tag, "_hburst"}, {29'b0, hburst_o}, 32'h0);
    check({tag, "_gnt_busy"}, {31'b0, gnt_o}, 32'd0);
    tick();
    check({tag, "_htrans_n2"}, {30'b0, htrans_o}, 32'h0);
    check({tag, "_rvalid_n2"}, {31'b0, rvalid_o}, 32'd0);
    if (we) check({tag, "_hwdata"}, hwdata_o, exp_hwdata);
    tick();
    check({tag, "_rvalid_n3"}, {31'b0, rvalid_o}, 32'd1);
    check({tag, "_err"}, {31'b0, err_o}, 32'd0);
    check({tag, "_rdata"}, rdata_o, exp_rdata);
    tick();
    check({tag, "_rvalid_n4"}, {31'b0, rvalid_o}, 32'd0);
    check({tag, "_gnt_n4"}, {31'b0, gnt_o}, 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_htrans", {30'b0, htrans_o}, 32'h0);
    check("rst_gnt", {31'b0, gnt_o}, 32'd0);
    check("rst_rvalid", {31'b0, rvalid_o}, 32'd0);
    check("rst_err", {31'b0, err_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_haddr", haddr_o, 32'h0);
    check("rst_hwdata", hwdata_o, 32'h0);
    check("rst_hwrite", {31'b0, hwrite_o}, 32'd0);
    check("rst_hsize", {29'b0, hsize_o}, 32'h0);
    hreset = 1'b0;
    tick();
    check("gnt_after_rst", {31'b0, gnt_o}, 32'd1);

    // Zero-wait transfers of each size
    xfer("wr_word", 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0);
    xfer("wr_byte", 1'b1, 2'd0, 32'h05, 32'h1234565A, 32'h0, 32'h5A5A5A5A, 32'h0);
    xfer("wr_half", 1'b1, 2'd1, 32'h02, 32'hFFFF1234, 32'h0, 32'h12341234, 32'h0);
    xfer("rd_half", 1'b0, 2'd1, 32'h02, 32'h0, 32'hAABBCCDD, 32'h0, 32'h0000AABB);
    xfer("rd_word", 1'b0, 2'd2, 32'h0C, 32'h0, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D);
    xfer("rd_byte1", 1'b0, 2'd0, 32'h21, 32'h0, 32'hAABBCCDD, 32'h0, 32'h000000CC);

    // Byte read at 0x13 with two DATA wait states: rvalid at N+5
    hready_i = 1'b1; hrdata_i = 32'hAABBCCDD;
    accept("rd_wait", 1'b0, 2'd0, 32'h13, 32'h0);
    check("rd_wait_htrans", {30'b0, htrans_o}, 32'h2);
    tick();                                   // N+2, DATA
    hready_i = 1'b0;
    tick();                                   // N+3
    check("rd_wait_rv_n3", {31'b0, rvalid_o}, 32'd0);
    tick();                                   // N+4
    check("rd_wait_rv_n4", {31'b0, rvalid_o}, 32'd0);
    hready_i = 1'b1;
    tick();                                   // N+5
    check("rd_wait_rv_n5", {31'b0, rvalid_o}, 32'd1);
    check("rd_wait_rdata", rdata_o, 32'h000000AA);
    tick();
    check("rd_wait_rv_end", {31'b0, rvalid_o}, 32'd0);

    // Address phase stalled for three cycles
    hready_i = 1'b0; hrdata_i = 32'h12345678;
    accept("stall", 1'b0, 2'd2, 32'h40, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("stall_htrans", {30'b0, htrans_o}, 32'h2);
      check("stall_haddr", haddr_o, 32'h40);
      check("stall_gnt", {31'b0, gnt_o}, 32'd0);
      tick();
    end
    check("stall_still_addr", {30'b0, htrans_o}, 32'h2);
    hready_i = 1'b1;
    tick();                                   // DATA
    check("stall_data_htrans", {30'b0, htrans_o}, 32'h0);
    tick();                                   // RSP
    check("stall_rvalid", {31'b0, rvalid_o}, 32'd1);
    check("stall_rdata", rdata_o, 32'h12345678);
    tick();

    // Two-cycle ERROR response
    hready_i = 1'b1; hrdata_i = 32'h55AA55AA;
    accept("err", 1'b0, 2'd2, 32'h80, 32'h0);
    tick();                                   // DATA
    hready_i = 1'b0; hresp_i = 1'b1;
    tick();                                   // first ERROR cycle sampled
    check("err_htrans_hold", {30'b0, htrans_o}, 32'h0);
    check("err_rv_early", {31'b0, rvalid_o}, 32'd0);
    hready_i = 1'b1;
    tick();
    check("err_rvalid", {31'b0, rvalid_o}, 32'd1);
    check("err_flag", {31'b0, err_o}, 32'd1);
    check("err_rdata", rdata_o, 32'h0);
    hresp_i = 1'b0;
    tick();
    check("err_single_pulse", {31'b0, rvalid_o}, 32'd0);
    check("err_cleared", {31'b0, err_o}, 32'd0);
    tick();
    check("err_no_repeat", {31'b0, rvalid_o}, 32'd0);

    // Reset asserted in DATA abandons the transfer
    hready_i = 1'b1;
    accept("rstd", 1'b1, 2'd2, 32'h100, 32'h11223344);
    tick();                                   // DATA
    hreset = 1'b1;
    tick();
    check("rstd_htrans", {30'b0, htrans_o}, 32'h0);
    check("rstd_rvalid", {31'b0, rvalid_o}, 32'd0);
    check("rstd_gnt_in_rst", {31'b0, gnt_o}, 32'd0);
    hreset = 1'b0;
    tick();
    check("rstd_gnt_after", {31'b0, gnt_o}, 32'd1);
    check("rstd_no_rvalid", {31'b0, rvalid_o}, 32'd0);
    tick();
    check("rstd_no_rvalid2", {31'b0, rvalid_o}, 32'd0);

    // Reset asserted in ADDR drops NONSEQ on the next cycle
    hready_i = 1'b0;
    accept("rsta", 1'b0, 2'd2, 32'h200, 32'h0);
    check("rsta_nonseq", {30'b0, htrans_o}, 32'h2);
    hreset = 1'b1;
    tick();
    check("rsta_htrans", {30'b0, htrans_o}, 32'h0);
    hreset = 1'b0; hready_i = 1'b1;
    tick();
    check("rsta_rvalid", {31'b0, rvalid_o}, 32'd0);

    // Half write to 0x21
`ifdef AHB_MST_ALIGN_CHK_EN
    accept("mis", 1'b1, 2'd1, 32'h21, 32'h0000BEEF);
    check("mis_no_nonseq", {30'b0, htrans_o}, 32'h0);
    check("mis_rvalid", {31'b0, rvalid_o}, 32'd1);
    check("mis_err", {31'b0, err_o}, 32'd1);
    check("mis_rdata", rdata_o, 32'h0);
    tick();
    check("mis_rv_end", {31'b0, rvalid_o}, 32'd0);
    check("mis_htrans_end", {30'b0, htrans_o}, 32'h0);
    tick();
    check("mis_gnt", {31'b0, gnt_o}, 32'd1);
`else
    xfer("mis_pass", 1'b1, 2'd1, 32'h21, 32'h0000BEEF, 32'h0, 32'hBEEFBEEF, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
